pixel_buffer_drain: RTL and testbench
=====================================

PIXEL_BUFFER_DRAIN -- requirements
Module: pixel_buffer_drain

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >=4).
REQ-002 SHALL have parameter NUM_PIXELS, default 307200, pixels per frame (640x480).
REQ-003 SHALL have parameter FB0_BASE, default 24'h000000, word base address of frame buffer 0.
REQ-004 SHALL have parameter FB1_BASE, default 24'h080000, word base address of frame buffer 1.
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-007 SHALL have port pb_we  in  1  shader pixel write strobe.
REQ-008 SHALL have port pb_data_in  in  $bits(pixel_buffer_entry_t)  {pixelID[18:0], color.r/g/b[7:0]}.
REQ-009 SHALL have port pb_full  out  1  FIFO full; shader must not write.
REQ-010 SHALL have port mem_wr_valid  out  1  frame-buffer write request.
REQ-011 SHALL have port mem_wr_addr  out  24  word address.
REQ-012 SHALL have port mem_wr_data  out  32  {8'h00, r, g, b}.
REQ-013 SHALL have port mem_wr_ready  in  1  memory accepts request.
REQ-014 SHALL have port vsync_pulse  in  1  one-cycle display vertical-sync strobe.
REQ-015 SHALL have port front_sel  out  1  buffer currently displayed (0=FB0, 1=FB1).
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse after buffer flip.
REQ-017 SHALL have port overflow  out  1  sticky: write attempted while full.

Function
REQ-018 Push SHALL occur when pb_we & ~pb_full; pb_full = (count == DEPTH), from registered count only.
REQ-019 Write while full SHALL be dropped and set overflow until reset; same-cycle pop does not make room.
REQ-020 States SHALL be DRAIN and FLIP_WAIT.
REQ-021 In DRAIN with FIFO non-empty and head pixelID < NUM_PIXELS, mem_wr_valid SHALL be 1.
REQ-022 mem_wr_addr SHALL be (front_sel ? FB0_BASE : FB1_BASE) + pixelID, so writes always target the back buffer.
REQ-023 mem_wr_valid/addr/data SHALL stay stable until mem_wr_ready; pop on valid & ready.
REQ-024 Head pixelID >= NUM_PIXELS SHALL be popped in one cycle with no memory write and no count.
REQ-025 Earliest mem_wr_valid SHALL be the cycle after the push (1-cycle latency).
REQ-026 pix_cnt (19 bits) SHALL increment per accepted write; on reaching NUM_PIXELS, next state FLIP_WAIT.
REQ-027 In FLIP_WAIT, mem_wr_valid SHALL be 0; pushes continue until full.
REQ-028 In FLIP_WAIT on vsync_pulse: toggle front_sel, clear pix_cnt, frame_done=1 next cycle, return to DRAIN.
REQ-029 vsync_pulse in DRAIN SHALL be ignored.
REQ-030 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-031 No combinational path SHALL exist from pb_we or mem_wr_ready to any output.

Reset
REQ-032 On rst=0, asynchronously: FIFO empty, pix_cnt 0, state DRAIN, front_sel 0, pb_full 0, mem_wr_valid 0, frame_done 0, overflow 0.
REQ-033 Reset mid-handshake SHALL abandon the pending write; no request issued until rst returns to 1 and a new push occurs.

Structure
REQ-034 pixelID_t, color_t, pixel_buffer_entry_t, fb_addr_t, NUM_PIXELS and FB base constants SHALL live in the shared package.
REQ-035 FIFO storage SHALL be one sub-module, sync_fifo (params WIDTH, DEPTH; push/pop/count/head).

Verification
REQ-036 Push pixelID 5, rgb 10/20/30, mem_wr_ready=1 -> next cycle mem_wr_valid=1, addr 24'h080005, data 32'h000A141E.
REQ-037 17 pushes, mem_wr_ready=0 -> pb_full=1 after 16th; 17th dropped; overflow=1; count stays 16.
REQ-038 mem_wr_ready held 0 for 5 cycles -> addr/data unchanged; single pop on ready.
REQ-039 NUM_PIXELS=4, 4 writes, vsync 3 cycles later -> valid 0 in FLIP_WAIT, front_sel=1, frame_done pulse, next addr FB0_BASE+id.
REQ-040 Push pixelID 307200 -> popped, no mem_wr_valid, pix_cnt unchanged.

Source files
------------

// File: rtl/pixel_buffer_drain_pkg.sv
// pixel_buffer_drain_pkg: shared pixel, colour and frame-buffer types and constants
package pixel_buffer_drain_pkg;
   typedef logic [18:0] pixel_id_t;
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } color_t;
   typedef struct packed {
      pixel_id_t pixel_id;
      color_t    color;
   } pixel_buffer_entry_t;
   typedef logic [23:0] fb_addr_t;
   typedef enum logic {DRAIN, FLIP_WAIT} drain_state_t;
   localparam int       NUM_PIXELS_DEFAULT = 307200;
   localparam fb_addr_t FB0_BASE_DEFAULT   = 24'h000000;
   localparam fb_addr_t FB1_BASE_DEFAULT   = 24'h080000;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and occupancy count
//   clk, rst (async, active-low)
//   push/din  : write din at the tail (caller guarantees not full)
//   pop       : drop the head entry (caller guarantees not empty)
//   count     : entries held, 0..DEPTH
//   head      : oldest entry, valid while count != 0
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);
   logic [WIDTH-1:0]         mem [DEPTH];
   logic [$clog2(DEPTH)-1:0] wr_ptr;
   logic [$clog2(DEPTH)-1:0] rd_ptr;

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;

   // pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/pixel_buffer_drain.sv
// pixel_buffer_drain: buffers shaded pixels and drains them into the back frame buffer
//   clk, rst (async, active-low)
//   pb_we, pb_data_in, pb_full       : shader-side pixel FIFO write port
//   mem_wr_valid/addr/data/ready     : frame-buffer write handshake
//   vsync_pulse                      : display vertical-sync strobe
//   front_sel                        : displayed buffer (0 = FB0, 1 = FB1)
//   frame_done                       : one-cycle pulse after a buffer flip
//   overflow                         : sticky, a write was attempted while full
module pixel_buffer_drain
   import pixel_buffer_drain_pkg::*;
#(
   parameter int       DEPTH      = 16,
   parameter int       NUM_PIXELS = NUM_PIXELS_DEFAULT,
   parameter fb_addr_t FB0_BASE   = FB0_BASE_DEFAULT,
   parameter fb_addr_t FB1_BASE   = FB1_BASE_DEFAULT
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   pb_we,
   input  logic [$bits(pixel_buffer_entry_t)-1:0] pb_data_in,
   output logic                                   pb_full,
   output logic                                   mem_wr_valid,
   output logic [23:0]                            mem_wr_addr,
   output logic [31:0]                            mem_wr_data,
   input  logic                                   mem_wr_ready,
   input  logic                                   vsync_pulse,
   output logic                                   front_sel,
   output logic                                   frame_done,
   output logic                                   overflow
);
   localparam int        CW = $clog2(DEPTH) + 1;
   localparam pixel_id_t NP = pixel_id_t'(NUM_PIXELS);

   logic [CW-1:0]       count;
   pixel_buffer_entry_t head;
   drain_state_t        state;
   drain_state_t        state_nxt;
   pixel_id_t           pix_cnt;
   logic                push;
   logic                pop;
   logic                accept;
   logic                drop;
   logic                flip;

   sync_fifo #(.WIDTH($bits(pixel_buffer_entry_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (pb_data_in),
      .count (count),
      .head  (head)
   );

   // full comes from the registered count only, so a same-cycle pop never makes room
   assign pb_full      = count == CW'(DEPTH);
   assign push         = pb_we & ~pb_full;
   assign mem_wr_valid = state == DRAIN && count != '0 && head.pixel_id < NP;
   // off-screen pixel IDs are discarded without touching memory or the pixel count
   assign drop         = state == DRAIN && count != '0 && head.pixel_id >= NP;
   assign accept       = mem_wr_valid & mem_wr_ready;
   assign pop          = accept | drop;
   assign flip         = state == FLIP_WAIT && vsync_pulse;
   // always write the buffer that is not on screen
   assign mem_wr_addr  = (front_sel ? FB0_BASE : FB1_BASE) + fb_addr_t'(head.pixel_id);
   assign mem_wr_data  = {8'h00, head.color};

   always_comb begin
      state_nxt = state;
      if (state == DRAIN) state_nxt = (accept && pix_cnt + 1'b1 == NP) ? FLIP_WAIT : DRAIN;
      else state_nxt = vsync_pulse ? DRAIN : FLIP_WAIT;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state      <= DRAIN;
         pix_cnt    <= '0;
         front_sel  <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= flip;
         overflow   <= overflow | (pb_we & pb_full);
         if (flip) begin
            front_sel <= ~front_sel;
            pix_cnt   <= '0;
         end else if (accept) pix_cnt <= pix_cnt + 1'b1;
      end
endmodule

// File: tb/tb_pixel_buffer_drain.sv
// tb_pixel_buffer_drain: directed self-checking bench for pixel_buffer_drain
module tb_pixel_buffer_drain;
   import pixel_buffer_drain_pkg::*;
   localparam int EW = $bits(pixel_buffer_entry_t);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          pb_we = 1'b0, mem_wr_ready = 1'b0, vsync_pulse = 1'b0;
   logic [EW-1:0] pb_data_in = '0;
   logic          pb_full, mem_wr_valid, front_sel, frame_done, overflow;
   logic [23:0]   mem_wr_addr;
   logic [31:0]   mem_wr_data;

   logic          pb_we4 = 1'b0, mem_wr_ready4 = 1'b0, vsync_pulse4 = 1'b0;
   logic [EW-1:0] pb_data_in4 = '0;
   logic          pb_full4, mem_wr_valid4, front_sel4, frame_done4, overflow4;
   logic [23:0]   mem_wr_addr4;
   logic [31:0]   mem_wr_data4;

   int vectors = 0;
   int miscompares = 0;

   pixel_buffer_drain dut (
      .clk(clk), .rst(rst), .pb_we(pb_we), .pb_data_in(pb_data_in), .pb_full(pb_full),
      .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_ready(mem_wr_ready), .vsync_pulse(vsync_pulse), .front_sel(front_sel),
      .frame_done(frame_done), .overflow(overflow)
   );

   pixel_buffer_drain #(.NUM_PIXELS(4)) dut4 (
      .clk(clk), .rst(rst), .pb_we(pb_we4), .pb_data_in(pb_data_in4), .pb_full(pb_full4),
      .mem_wr_valid(mem_wr_valid4), .mem_wr_addr(mem_wr_addr4), .mem_wr_data(mem_wr_data4),
      .mem_wr_ready(mem_wr_ready4), .vsync_pulse(vsync_pulse4), .front_sel(front_sel4),
      .frame_done(frame_done4), .overflow(overflow4)
   );

   task automatic push(input logic [18:0] id, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      pb_data_in = {id, r, g, b};
      pb_we = 1'b1;
      @(posedge clk); #1;
      pb_we = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      vectors++; if (pb_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", pb_full); end
      vectors++; if (mem_wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", mem_wr_valid); end
      vectors++; if (front_sel !== 1'b0) begin miscompares++; $display("FAIL reset_front: got %b want 0", front_sel); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", frame_done); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      vectors++; if (mem_wr_valid4 !== 1'b0) begin miscompares++; $display("FAIL reset_valid4: got %b want 0", mem_wr_valid4); end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_write;
      mem_wr_ready = 1'b1;
      push(19'd5, 8'd10, 8'd20, 8'd30);
      @(negedge clk);
      vectors++; if (mem_wr_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", mem_wr_valid); end
      vectors++; if (mem_wr_addr !== 24'h080005) begin miscompares++; $display("FAIL single_addr: got %h want 080005", mem_wr_addr); end
      vectors++; if (mem_wr_data !== 32'h000A141E) begin miscompares++; $display("FAIL single_data: got %h want 000a141e", mem_wr_data); end
      @(negedge clk);
      vectors++; if (mem_wr_valid !== 1'b0) begin miscompares++; $display("FAIL single_popped: got %b want 0", mem_wr_valid); end
      vectors++; if (dut.pix_cnt !== 19'd1) begin miscompares++; $display("FAIL single_pixcnt: got %0d want 1", dut.pix_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_full_overflow;
      mem_wr_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         pb_data_in = {19'(100 + i), 8'(i), 8'h55, 8'hAA};
         pb_we = 1'b1;
         @(posedge clk); #1;
         if (i == 14) begin
            vectors++; if (pb_full !== 1'b0) begin miscompares++; $display("FAIL full_at15: got %b want 0", pb_full); end
         end
         if (i == 15) begin
            vectors++; if (pb_full !== 1'b1) begin miscompares++; $display("FAIL full_at16: got %b want 1", pb_full); end
            vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b want 0", overflow); end
         end
      end
      pb_we = 1'b0;
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", overflow); end
      vectors++; if (pb_full !== 1'b1) begin miscompares++; $display("FAIL full_after17: got %b want 1", pb_full); end
   endtask

   task automatic test_stall;
      int n;
      logic [23:0] last;
      n = 0;
      last = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++; if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 24'h080064 || mem_wr_data !== 32'h000055AA) begin
            miscompares++; $display("FAIL stall_hold%0d: got v=%b a=%h d=%h want v=1 a=080064 d=000055aa", c, mem_wr_valid, mem_wr_addr, mem_wr_data);
         end
      end
      @(posedge clk); #1;
      mem_wr_ready = 1'b1;
      @(posedge clk); #1;
      mem_wr_ready = 1'b0;
      @(negedge clk);
      vectors++; if (mem_wr_addr !== 24'h080065 || mem_wr_data !== 32'h000155AA) begin
         miscompares++; $display("FAIL stall_onepop: got a=%h d=%h want a=080065 d=000155aa", mem_wr_addr, mem_wr_data);
      end
      vectors++; if (pb_full !== 1'b0) begin miscompares++; $display("FAIL stall_notfull: got %b want 0", pb_full); end
      mem_wr_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (mem_wr_valid) begin n++; last = mem_wr_addr; end
         @(negedge clk);
      end
      vectors++; if (n != 15) begin miscompares++; $display("FAIL drain_count: got %0d want 15", n); end
      vectors++; if (last !== 24'h080073) begin miscompares++; $display("FAIL drain_last: got %h want 080073", last); end
      vectors++; if (dut.pix_cnt !== 19'd17) begin miscompares++; $display("FAIL drain_pixcnt: got %0d want 17", dut.pix_cnt); end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      @(posedge clk); #1;
   endtask

   task automatic test_drop;
      push(19'd307200, 8'd1, 8'd2, 8'd3);
      @(negedge clk);
      vectors++; if (mem_wr_valid !== 1'b0) begin miscompares++; $display("FAIL drop_novalid: got %b want 0", mem_wr_valid); end
      @(negedge clk);
      vectors++; if (mem_wr_valid !== 1'b0) begin miscompares++; $display("FAIL drop_after: got %b want 0", mem_wr_valid); end
      vectors++; if (dut.pix_cnt !== 19'd17) begin miscompares++; $display("FAIL drop_pixcnt: got %0d want 17", dut.pix_cnt); end
      @(posedge clk); #1;
      push(19'd7, 8'd1, 8'd2, 8'd3);
      @(negedge clk);
      vectors++; if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 24'h080007 || mem_wr_data !== 32'h00010203) begin
         miscompares++; $display("FAIL drop_next: got v=%b a=%h d=%h want v=1 a=080007 d=00010203", mem_wr_valid, mem_wr_addr, mem_wr_data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mid_reset;
      mem_wr_ready = 1'b0;
      push(19'd9, 8'd4, 8'd5, 8'd6);
      @(negedge clk);
      vectors++; if (mem_wr_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_pending: got %b want 1", mem_wr_valid); end
      #1 rst = 1'b0;
      #1;
      vectors++; if (mem_wr_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_async: got %b want 0", mem_wr_valid); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL midrst_ovf: got %b want 0", overflow); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (mem_wr_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_abandon: got %b want 0", mem_wr_valid); end
      vectors++; if (dut.pix_cnt !== 19'd0) begin miscompares++; $display("FAIL midrst_pixcnt: got %0d want 0", dut.pix_cnt); end
   endtask

   task automatic test_vsync_in_drain;
      vsync_pulse4 = 1'b1;
      @(posedge clk); #1;
      vsync_pulse4 = 1'b0;
      @(negedge clk);
      vectors++; if (front_sel4 !== 1'b0 || frame_done4 !== 1'b0) begin
         miscompares++; $display("FAIL vsync_ignored: got fs=%b fd=%b want fs=0 fd=0", front_sel4, frame_done4);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_flip;
      mem_wr_ready4 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pb_data_in4 = {(i < 4) ? 19'(i) : 19'd1, 8'(i), 8'h00, 8'h00};
         pb_we4 = 1'b1;
         @(posedge clk); #1;
         if (i < 4) begin
            vectors++; if (mem_wr_valid4 !== 1'b1 || mem_wr_addr4 !== 24'h080000 + 24'(i)) begin
               miscompares++; $display("FAIL flip_write%0d: got v=%b a=%h want v=1 a=%h", i, mem_wr_valid4, mem_wr_addr4, 24'h080000 + 24'(i));
            end
         end else begin
            vectors++; if (mem_wr_valid4 !== 1'b0) begin miscompares++; $display("FAIL flip_wait_valid: got %b want 0", mem_wr_valid4); end
         end
      end
      pb_we4 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         vectors++; if (mem_wr_valid4 !== 1'b0 || front_sel4 !== 1'b0 || frame_done4 !== 1'b0) begin
            miscompares++; $display("FAIL flip_hold%0d: got v=%b fs=%b fd=%b want 0 0 0", c, mem_wr_valid4, front_sel4, frame_done4);
         end
      end
      vsync_pulse4 = 1'b1;
      @(posedge clk); #1;
      vsync_pulse4 = 1'b0;
      vectors++; if (front_sel4 !== 1'b1) begin miscompares++; $display("FAIL flip_front: got %b want 1", front_sel4); end
      vectors++; if (frame_done4 !== 1'b1) begin miscompares++; $display("FAIL flip_done: got %b want 1", frame_done4); end
      vectors++; if (mem_wr_valid4 !== 1'b1 || mem_wr_addr4 !== 24'h000001) begin
         miscompares++; $display("FAIL flip_fb0addr: got v=%b a=%h want v=1 a=000001", mem_wr_valid4, mem_wr_addr4);
      end
      @(posedge clk); #1;
      vectors++; if (frame_done4 !== 1'b0) begin miscompares++; $display("FAIL flip_donepulse: got %b want 0", frame_done4); end
      vectors++; if (mem_wr_valid4 !== 1'b0) begin miscompares++; $display("FAIL flip_drained: got %b want 0", mem_wr_valid4); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      test_reset();
      test_single_write();
      test_full_overflow();
      test_stall();
      test_drop();
      test_mid_reset();
      test_vsync_in_drain();
      test_flip();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
